// File: rtl/monkey_pkg.sv
// Shared definitions for the monkey collision detector.
//   EDGE_* : bit positions inside an edge code
//   edge_code_t : one bit per sprite edge touched
//   coll_state_t : detector sequencing state
package monkey_pkg;

  localparam int EDGE_BOTTOM = 0;
  localparam int EDGE_RIGHT  = 1;
  localparam int EDGE_TOP    = 2;
  localparam int EDGE_LEFT   = 3;

  typedef logic [3:0] edge_code_t;

  typedef enum logic {
    WAIT_FIRST = 1'b0,
    RUN        = 1'b1
  } coll_state_t;

endpackage

// File: rtl/monkey_edge_classify.sv
// Combinational edge classifier for one monkey sprite pixel.
//   offsetX, offsetY : pixel position inside the sprite (unsigned)
//   edge_code        : edge bands the pixel lies in (corner pixels set two bits)
// Out-of-range offsets fall into the right/bottom bands by plain comparison.
module monkey_edge_classify
  import monkey_pkg::*;
#(
  parameter int OBJECT_WIDTH  = 32,
  parameter int OBJECT_HEIGHT = 32,
  parameter int EDGE_MARGIN   = 4
) (
  input  logic [10:0] offsetX,
  input  logic [10:0] offsetY,
  output edge_code_t  edge_code
);

  localparam logic [10:0] MARGIN       = 11'(EDGE_MARGIN);
  localparam logic [10:0] RIGHT_START  = 11'(OBJECT_WIDTH - EDGE_MARGIN);
  localparam logic [10:0] BOTTOM_START = 11'(OBJECT_HEIGHT - EDGE_MARGIN);

  always_comb begin
    edge_code              = '0;
    edge_code[EDGE_LEFT]   = (offsetX <  MARGIN);
    edge_code[EDGE_RIGHT]  = (offsetX >= RIGHT_START);
    edge_code[EDGE_TOP]    = (offsetY <  MARGIN);
    edge_code[EDGE_BOTTOM] = (offsetY >= BOTTOM_START);
  end

endmodule

// File: rtl/monkey_collision_detector.sv
// Per-frame monkey collision detector.
// Accumulates rope/ground overlaps and touched sprite edges over a frame and
// publishes them at the next startOfFrame, holding them for the whole frame.
//   clk, resetN            : clock, async active-low reset
//   startOfFrame           : one-cycle frame start pulse
//   monkey_DR, offsetX/Y   : monkey sprite draw flag and in-sprite position
//   rope_DR, ground_DR     : rope / ground draw flags
//   collision_with_rope    : rope overlap in previous frame
//   collision_with_ground  : ground overlap in previous frame or within hold
//   HitEdgeCode            : edges touched in previous frame
//
// state      | meaning
// WAIT_FIRST | after reset, partial frame discarded, outputs held at zero
// RUN        | accumulate during frame, publish on every startOfFrame
module monkey_collision_detector
  import monkey_pkg::*;
#(
  parameter int OBJECT_WIDTH       = 32,
  parameter int OBJECT_HEIGHT      = 32,
  parameter int EDGE_MARGIN        = 4,
  parameter int GROUND_HOLD_FRAMES = 2
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        monkey_DR,
  input  logic [10:0] offsetX,
  input  logic [10:0] offsetY,
  input  logic        rope_DR,
  input  logic        ground_DR,
  output logic        collision_with_rope,
  output logic        collision_with_ground,
  output logic [3:0]  HitEdgeCode
);

  localparam int HOLD_W = (GROUND_HOLD_FRAMES > 0) ? $clog2(GROUND_HOLD_FRAMES + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(GROUND_HOLD_FRAMES);

  coll_state_t       state_q, state_d;
  logic              acc_rope_q, acc_rope_d;
  logic              acc_ground_q, acc_ground_d;
  edge_code_t        acc_edge_q, acc_edge_d;
  logic              rope_q, rope_d;
  logic              ground_q, ground_d;
  edge_code_t        edge_q, edge_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  edge_code_t pix_edge;
  edge_code_t hit_edge;
  logic       hit_rope, hit_ground;

  monkey_edge_classify #(
    .OBJECT_WIDTH (OBJECT_WIDTH),
    .OBJECT_HEIGHT(OBJECT_HEIGHT),
    .EDGE_MARGIN  (EDGE_MARGIN)
  ) u_classify (
    .offsetX  (offsetX),
    .offsetY  (offsetY),
    .edge_code(pix_edge)
  );

  // Current-cycle contribution; offsets are only meaningful on a hit pixel.
  assign hit_rope   = monkey_DR & rope_DR;
  assign hit_ground = monkey_DR & ground_DR;
  assign hit_edge   = (hit_rope | hit_ground) ? pix_edge : '0;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= WAIT_FIRST;
      acc_rope_q   <= 1'b0;
      acc_ground_q <= 1'b0;
      acc_edge_q   <= '0;
      rope_q       <= 1'b0;
      ground_q     <= 1'b0;
      edge_q       <= '0;
      hold_q       <= '0;
    end else begin
      state_q      <= state_d;
      acc_rope_q   <= acc_rope_d;
      acc_ground_q <= acc_ground_d;
      acc_edge_q   <= acc_edge_d;
      rope_q       <= rope_d;
      ground_q     <= ground_d;
      edge_q       <= edge_d;
      hold_q       <= hold_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    acc_rope_d   = acc_rope_q;
    acc_ground_d = acc_ground_q;
    acc_edge_d   = acc_edge_q;
    rope_d       = rope_q;
    ground_d     = ground_q;
    edge_d       = edge_q;
    hold_d       = hold_q;

    case (state_q)
      WAIT_FIRST: begin
        acc_rope_d   = 1'b0;
        acc_ground_d = 1'b0;
        acc_edge_d   = '0;
        if (startOfFrame) begin
          // First pulse starts the first real frame but has nothing to report.
          state_d      = RUN;
          acc_rope_d   = hit_rope;
          acc_ground_d = hit_ground;
          acc_edge_d   = hit_edge;
          rope_d       = 1'b0;
          ground_d     = 1'b0;
          edge_d       = '0;
          hold_d       = '0;
        end
      end
      RUN: begin
        if (startOfFrame) begin
          rope_d = acc_rope_q;
          edge_d = acc_edge_q;
          if (acc_ground_q) begin
            ground_d = 1'b1;
            hold_d   = HOLD_LOAD;
          end else if (hold_q != '0) begin
            ground_d = 1'b1;
            hold_d   = hold_q - HOLD_W'(1);
          end else begin
            ground_d = 1'b0;
          end
          // A hit coincident with the pulse belongs to the new frame.
          acc_rope_d   = hit_rope;
          acc_ground_d = hit_ground;
          acc_edge_d   = hit_edge;
        end else begin
          acc_rope_d   = acc_rope_q | hit_rope;
          acc_ground_d = acc_ground_q | hit_ground;
          acc_edge_d   = acc_edge_q | hit_edge;
        end
      end
      default: state_d = WAIT_FIRST;
    endcase
  end

  assign collision_with_rope   = rope_q;
  assign collision_with_ground = ground_q;
  assign HitEdgeCode           = edge_q;

endmodule

// File: tb/tb_monkey_collision_detector.sv
module tb_monkey_collision_detector;

  localparam int W    = 32;
  localparam int H    = 32;
  localparam int M    = 4;
  localparam int HOLD = 2;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic        monkey_DR;
  logic [10:0] offsetX;
  logic [10:0] offsetY;
  logic        rope_DR;
  logic        ground_DR;
  logic        collision_with_rope;
  logic        collision_with_ground;
  logic [3:0]  HitEdgeCode;

  always #5 clk = ~clk;

  monkey_collision_detector #(
    .OBJECT_WIDTH      (W),
    .OBJECT_HEIGHT     (H),
    .EDGE_MARGIN       (M),
    .GROUND_HOLD_FRAMES(HOLD)
  ) dut (
    .clk                  (clk),
    .resetN               (resetN),
    .startOfFrame         (startOfFrame),
    .monkey_DR            (monkey_DR),
    .offsetX              (offsetX),
    .offsetY              (offsetY),
    .rope_DR              (rope_DR),
    .ground_DR            (ground_DR),
    .collision_with_rope  (collision_with_rope),
    .collision_with_ground(collision_with_ground),
    .HitEdgeCode          (HitEdgeCode)
  );

  typedef struct {
    int x;
    int y;
    bit r;
    bit g;
  } hit_t;

  typedef struct {
    bit         r;
    bit         g;
    logic [3:0] e;
  } exp_t;

  hit_t frame_hits[$];
  exp_t expq[$];
  exp_t last_exp;
  bit   started;
  int   hold_left;
  int   checks   = 0;
  int   failures = 0;
  logic sof_q;

  // Edge rule straight from the sprite geometry: bit0 bottom, bit1 right, bit2 top, bit3 left.
  function automatic logic [3:0] edges_of(int x, int y);
    logic [3:0] e = 4'b0000;
    if (y >= H - M) e = e | 4'b0001;
    if (x >= W - M) e = e | 4'b0010;
    if (y < M)      e = e | 4'b0100;
    if (x < M)      e = e | 4'b1000;
    return e;
  endfunction

  task automatic check3(string name, exp_t ex);
    checks++;
    if (collision_with_rope !== ex.r || collision_with_ground !== ex.g || HitEdgeCode !== ex.e) begin
      failures++;
      $display("FAIL %s t=%0t: got rope=%0b ground=%0b edge=%b, want rope=%0b ground=%0b edge=%b",
               name, $time, collision_with_rope, collision_with_ground, HitEdgeCode, ex.r, ex.g, ex.e);
    end
  endtask

  // Reference: summarise the finished frame's hit list into the published result.
  task automatic publish();
    exp_t ex;
    bit   gh;
    ex.r = 1'b0;
    ex.g = 1'b0;
    ex.e = 4'b0000;
    gh   = 1'b0;
    if (started) begin
      foreach (frame_hits[i]) begin
        if (frame_hits[i].r) ex.r = 1'b1;
        if (frame_hits[i].g) gh = 1'b1;
        ex.e = ex.e | edges_of(frame_hits[i].x, frame_hits[i].y);
      end
      if (gh) begin
        ex.g      = 1'b1;
        hold_left = HOLD;
      end else if (hold_left > 0) begin
        hold_left--;
        ex.g = 1'b1;
      end
    end
    expq.push_back(ex);
  endtask

  task automatic pix(bit sof, bit mdr, int x, int y, bit r, bit g);
    hit_t h;
    @(negedge clk);
    startOfFrame = sof;
    monkey_DR    = mdr;
    offsetX      = 11'(x);
    offsetY      = 11'(y);
    rope_DR      = r;
    ground_DR    = g;
    if (sof) begin
      publish();
      started = 1'b1;
      frame_hits.delete();
    end
    if (mdr && (r || g) && started) begin
      h.x = x; h.y = y; h.r = r; h.g = g;
      frame_hits.push_back(h);
    end
    @(posedge clk);
  endtask

  task automatic idle(int n);
    repeat (n) pix(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic sof_blank();
    pix(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic check_now(string name, bit r, bit g, logic [3:0] e);
    exp_t ex;
    ex.r = r; ex.g = g; ex.e = e;
    #1;
    check3(name, ex);
  endtask

  task automatic do_reset();
    exp_t z;
    z.r = 1'b0; z.g = 1'b0; z.e = 4'b0000;
    @(negedge clk);
    #1;
    startOfFrame = 1'b0;
    monkey_DR    = 1'b0;
    rope_DR      = 1'b0;
    ground_DR    = 1'b0;
    resetN       = 1'b0;
    #1;
    check3("reset_clear", z);
    started   = 1'b0;
    hold_left = 0;
    frame_hits.delete();
    expq.delete();
    last_exp = z;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
  endtask

  always @(posedge clk or negedge resetN) begin
    if (!resetN) sof_q <= 1'b0;
    else         sof_q <= startOfFrame;
  end

  // Monitor: a pulse seen at the last edge means a fresh result is on the outputs;
  // otherwise the outputs must still equal the last published result.
  always @(negedge clk) begin
    if (resetN === 1'b1) begin
      if (sof_q) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL publish_queue t=%0t: got output update, want a queued expectation", $time);
        end else begin
          last_exp = expq.pop_front();
          check3("publish", last_exp);
        end
      end else begin
        check3("hold_stable", last_exp);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    monkey_DR    = 1'b0;
    offsetX      = '0;
    offsetY      = '0;
    rope_DR      = 1'b0;
    ground_DR    = 1'b0;
    started      = 1'b0;
    hold_left    = 0;
    last_exp.r   = 1'b0;
    last_exp.g   = 1'b0;
    last_exp.e   = 4'b0000;
    #1;
    check_now("reset_state", 1'b0, 1'b0, 4'b0000);
    repeat (2) @(negedge clk);
    resetN = 1'b1;

    // Partial first frame is discarded; first pulse publishes zeros.
    idle(1);
    pix(1'b0, 1'b1, 16, 30, 1'b0, 1'b1);
    idle(2);
    sof_blank();
    check_now("first_pulse_zero", 1'b0, 1'b0, 4'b0000);
    pix(1'b0, 1'b1, 16, 30, 1'b0, 1'b1);
    idle(2);
    sof_blank();
    check_now("ground_bottom", 1'b0, 1'b1, 4'b0001);

    // Ground hold: stays for two more frames, then drops.
    idle(3); sof_blank();
    check_now("ground_hold1", 1'b0, 1'b1, 4'b0000);
    idle(3); sof_blank();
    check_now("ground_hold2", 1'b0, 1'b1, 4'b0000);
    idle(3); sof_blank();
    check_now("ground_drop", 1'b0, 1'b0, 4'b0000);

    // Rope corner plus interior.
    pix(1'b0, 1'b1, 1, 1, 1'b1, 1'b0);
    pix(1'b0, 1'b1, 16, 16, 1'b1, 1'b0);
    idle(1);
    sof_blank();
    check_now("rope_corner", 1'b1, 1'b0, 4'b1100);

    // Hit coincident with the pulse belongs to the new frame.
    pix(1'b1, 1'b1, 31, 5, 1'b1, 1'b0);
    check_now("coincident_excluded", 1'b0, 1'b0, 4'b0000);
    idle(3);
    sof_blank();
    check_now("coincident_next", 1'b1, 1'b0, 4'b0010);

    // Mid-frame reset.
    pix(1'b0, 1'b1, 2, 16, 1'b0, 1'b1);
    pix(1'b0, 1'b1, 16, 0, 1'b1, 1'b0);
    do_reset();
    idle(2);
    sof_blank();
    check_now("post_reset_zero", 1'b0, 1'b0, 4'b0000);
    pix(1'b0, 1'b1, 16, 30, 1'b0, 1'b1);
    idle(1);
    sof_blank();
    check_now("post_reset_resume", 1'b0, 1'b1, 4'b0001);

    // Let the hold expire, then a frame with rope/ground but no monkey.
    repeat (3) begin idle(2); sof_blank(); end
    repeat (6) pix(1'b0, 1'b0, 0, 31, 1'b1, 1'b1);
    sof_blank();
    check_now("no_monkey", 1'b0, 1'b0, 4'b0000);

    // Back-to-back pulses: one-cycle frame.
    pix(1'b1, 1'b1, 0, 0, 1'b1, 1'b0);
    pix(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    check_now("back_to_back", 1'b1, 1'b0, 4'b1100);

    // Randomized frames against the reference model.
    for (int f = 0; f < 60; f++) begin
      int n;
      if (f == 30) do_reset();
      n = $urandom_range(0, 12);
      pix(1'b1, ($urandom_range(0, 3) == 0), $urandom_range(0, 35), $urandom_range(0, 35),
          ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
      for (int c = 0; c < n; c++) begin
        pix(1'b0, ($urandom_range(0, 3) == 0), $urandom_range(0, 35), $urandom_range(0, 35),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0));
      end
    end
    sof_blank();
    idle(3);

    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL queue_drained: got %0d pending, want 0", expq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
